// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types and opcodes for the sequential unsigned multiply/divide unit.
// ALU opcodes must match the encoding used by the core's shared ALU.
package alu_muldiv_seq_pkg;

   localparam int XLEN     = 32;
   localparam int ALU_OP_W = 5;
   localparam int CNT_W    = 5;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'd1;

   typedef enum logic [1:0] {
      MD_MUL   = 2'd0,
      MD_MULHU = 2'd1,
      MD_DIVU  = 2'd2,
      MD_REMU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   function automatic logic is_div(input md_op_e op);
      return (op == MD_DIVU) || (op == MD_REMU);
   endfunction

   // hi/lo carry {product_hi, product_lo} for multiply and {rem, quo} for divide.
   function automatic logic [XLEN-1:0] md_select(input md_op_e op,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
      case (op)
         MD_MULHU: return hi;
         MD_REMU:  return hi;
         default:  return lo;
      endcase
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
// Handshake: start is accepted on a rising edge only while busy=0 and kill=0;
// done is a single-cycle pulse and result holds until the next accept or reset.
interface alu_muldiv_seq_if;
   import alu_muldiv_seq_pkg::*;

   logic             start;
   md_op_e           md_op;
   logic [XLEN-1:0]  op_a;
   logic [XLEN-1:0]  op_b;
   logic             kill;
   logic             busy;
   logic             done;
   logic [XLEN-1:0]  result;
   md_state_e        state;

   modport master (
      output start, md_op, op_a, op_b, kill,
      input  busy, done, result, state
   );

   modport slave (
      input  start, md_op, op_a, op_b, kill,
      output busy, done, result, state
   );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU
// for one add (shift-add multiply) or subtract (restoring divide) per cycle.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   alu_muldiv_seq_if.slave     md,
   output logic                alu_req,
   output logic [XLEN-1:0]     alu_a,
   output logic [XLEN-1:0]     alu_b,
   output logic [ALU_OP_W-1:0] alu_op,
   input  logic [XLEN-1:0]     alu_result
);

   md_state_e       state;
   md_op_e          op_q;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] opnd;
   logic            done_q;
   logic [XLEN-1:0] result_q;

   logic [XLEN-1:0] s32;
   logic            mul_carry;
   logic            div_take;

   // s32 drops bit 32 of the shifted remainder; hi[31] stands in for it.
   always_comb begin
      alu_req   = (state == ST_RUN);
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = ALU_ADD;
      mul_carry = 1'b0;
      div_take  = 1'b0;
      s32       = {hi[XLEN-2:0], lo[XLEN-1]};
      if (state == ST_RUN) begin
         if (is_div(op_q)) begin
            alu_op   = ALU_SUB;
            alu_a    = s32;
            alu_b    = opnd;
            div_take = hi[XLEN-1] | (s32 >= opnd);
         end else begin
            alu_a     = hi;
            alu_b     = lo[0] ? opnd : '0;
            mul_carry = (alu_result < hi);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         op_q     <= MD_MUL;
         count    <= '0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (md.start && !md.kill) begin
                  op_q  <= md.md_op;
                  count <= '0;
                  hi    <= '0;
                  state <= ST_RUN;
                  if (is_div(md.md_op)) begin
                     lo   <= md.op_a;
                     opnd <= md.op_b;
                  end else begin
                     lo   <= md.op_b;
                     opnd <= md.op_a;
                  end
               end
            end
            ST_RUN: begin
               if (md.kill) begin
                  state <= ST_IDLE;
               end else begin
                  if (is_div(op_q)) begin
                     hi <= div_take ? alu_result : s32;
                     lo <= {lo[XLEN-2:0], div_take};
                  end else begin
                     hi <= {mul_carry, alu_result[XLEN-1:1]};
                     lo <= {alu_result[0], lo[XLEN-1:1]};
                  end
                  count <= count + 1'b1;
                  if (count == CNT_W'(XLEN - 1)) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               if (!md.kill) begin
                  done_q   <= 1'b1;
                  result_q <= md_select(op_q, hi, lo);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign md.busy   = (state != ST_IDLE);
   assign md.done   = done_q;
   assign md.result = result_q;
   assign md.state  = state;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed RV32M corner cases, protocol
// (ignored start, kill, async reset) and random operations against an arithmetic model.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  alu_muldiv_seq_if mdi();

  alu_muldiv_seq #(.XLEN(32), .ALU_OP_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .md         (mdi.slave),
    .alu_req    (alu_req),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  // shared ALU stand-in
  always_comb begin
    alu_result = (alu_op == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);
  end

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_md(input md_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      MD_MUL:   return p[31:0];
      MD_MULHU: return p[63:32];
      MD_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [31:0] exp_res);
    check({tag, " busy"},    {31'd0, mdi.busy}, 32'd0);
    check({tag, " done"},    {31'd0, mdi.done}, 32'd0);
    check({tag, " result"},  mdi.result, exp_res);
    check({tag, " alu_req"}, {31'd0, alu_req}, 32'd0);
  endtask

  // watch n cycles and require that no done pulse appears
  task automatic expect_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (mdi.done) seen++;
    end
    check({tag, " no_done"}, seen, 32'd0);
  endtask

  // driver: one operation, optionally with start pulses and operand churn while busy
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input string tag);
    int k;
    int req;
    bit seen;
    logic [31:0] exp;
    @(negedge clk);
    mdi.start = 1'b1;
    mdi.md_op = op;
    mdi.op_a  = a;
    mdi.op_b  = b;
    exp_q.push_back(ref_md(op, a, b));
    @(posedge clk); #1;
    mdi.start = 1'b0;
    mdi.op_a  = $urandom;
    mdi.op_b  = $urandom;
    mdi.md_op = md_op_e'($urandom_range(0, 3));
    k = 0;
    req = 0;
    seen = 1'b0;
    while (k < 60 && !seen) begin
      if (alu_req) req++;
      if (mdi.done) begin
        seen = 1'b1;
      end else begin
        if (noise) begin
          mdi.start = 1'($urandom_range(0, 1));
          mdi.md_op = md_op_e'($urandom_range(0, 3));
          mdi.op_a  = $urandom;
          mdi.op_b  = $urandom;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    mdi.start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, k, 32'd33);
    check({tag, " alu_req_cycles"}, req, 32'd32);
    check({tag, " result"}, mdi.result, exp);
    last_res = exp;
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {31'd0, mdi.done}, 32'd0);
    check({tag, " busy_after"}, {31'd0, mdi.busy}, 32'd0);
    check({tag, " result_hold"}, mdi.result, exp);
  endtask

  initial begin
    md_op_e rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_vec = 0;
    n_err = 0;
    last_res = 32'd0;
    mdi.start = 1'b0;
    mdi.md_op = MD_MUL;
    mdi.op_a  = 32'd0;
    mdi.op_b  = 32'd0;
    mdi.kill  = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("reset", 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    check("reset alu_op", {27'd0, alu_op}, {27'd0, ALU_ADD});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed arithmetic
    run_op(MD_MUL,   32'd7,          32'd6,          1'b0, "mul_7x6");
    run_op(MD_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, "mulhu_max");
    run_op(MD_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, "mul_max");
    run_op(MD_DIVU,  32'd100,        32'd7,          1'b0, "divu_100_7");
    run_op(MD_REMU,  32'd100,        32'd7,          1'b0, "remu_100_7");
    run_op(MD_DIVU,  32'hFFFF_FFFF,  32'h8000_0001,  1'b0, "divu_bigdvs");
    run_op(MD_REMU,  32'hFFFF_FFFF,  32'h8000_0001,  1'b0, "remu_bigdvs");
    run_op(MD_DIVU,  32'h0000_1234,  32'd0,          1'b0, "divu_zero");
    run_op(MD_REMU,  32'h0000_1234,  32'd0,          1'b0, "remu_zero");

    // start pulses and operand changes while busy must be ignored
    run_op(MD_MUL,   32'h1234_5678,  32'h0000_9ABC,  1'b1, "noise_mul");
    run_op(MD_REMU,  32'hDEAD_BEEF,  32'h0001_0003,  1'b1, "noise_remu");

    // kill while count=10
    @(negedge clk);
    mdi.start = 1'b1;
    mdi.md_op = MD_MUL;
    mdi.op_a  = 32'd5;
    mdi.op_b  = 32'd5;
    @(posedge clk); #1;
    mdi.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    mdi.kill = 1'b1;
    @(posedge clk); #1;
    check("kill busy", {31'd0, mdi.busy}, 32'd0);
    check("kill alu_req", {31'd0, alu_req}, 32'd0);
    // start together with kill in IDLE is ignored
    mdi.start = 1'b1;
    @(posedge clk); #1;
    check("kill_start busy", {31'd0, mdi.busy}, 32'd0);
    mdi.start = 1'b0;
    mdi.kill  = 1'b0;
    expect_no_done("kill", 40);
    check("kill result_kept", mdi.result, last_res);
    run_op(MD_DIVU, 32'd1000, 32'd33, 1'b0, "after_kill");

    // asynchronous reset off a clock edge in the middle of RUN
    @(negedge clk);
    mdi.start = 1'b1;
    mdi.md_op = MD_MULHU;
    mdi.op_a  = 32'hCAFE_F00D;
    mdi.op_b  = 32'h1357_9BDF;
    @(posedge clk); #1;
    mdi.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst", 32'd0);
    check("async_rst alu_a", alu_a, 32'd0);
    check("async_rst alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res = 32'd0;
    expect_no_done("async_rst", 40);
    check("async_rst result", mdi.result, last_res);
    run_op(MD_MUL, 32'd9, 32'd9, 1'b0, "mul_9x9");

    // random operations
    for (int i = 0; i < 40; i++) begin
      rop = md_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer for unsigned RV32M multiply and divide: MUL, MULHU, DIVU, REMU.
- Adds no arithmetic unit of its own. It borrows the core's shared ALU one iteration per cycle: ALU_ADD for shift-add multiply, ALU_SUB for restoring division.
- Sits beside the execute stage. The top-level ALU input mux grants the ALU to this block while alu_req=1.

Parameters:
- XLEN, 32, operand/result width; the only supported value is 32.
- ALU_OP_W, 5, width of the ALU opcode bus; matches the shared ALU.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- md_op  in  2  operation: MD_MUL=0, MD_MULHU=1, MD_DIVU=2, MD_REMU=3.
- op_a  in  32  multiplicand or dividend; sampled only on accept.
- op_b  in  32  multiplier or divisor; sampled only on accept.
- kill  in  1  pipeline flush; abandons the current operation.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  final value; held until the next accept or reset.
- alu_req  out  1  high in RUN; ALU owned by this block.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  5  ALU_ADD or ALU_SUB.
- alu_result  in  32  combinational result from the shared ALU.

Behaviour:
- Reset, asynchronous: state=IDLE, count=0, all internal registers 0; busy=0, done=0, result=0, alu_req=0, alu_a=0, alu_b=0, alu_op=ALU_ADD.
- State IDLE:
  - start=1 and kill=0: latch md_op, op_a, op_b; count=0; go to RUN.
  - Multiply init: hi=0, lo=op_b, mcand=op_a.
  - Divide init: rem=0, quo=op_a, dvs=op_b.
- State RUN, exactly 32 cycles (count 0..31). alu_* outputs are combinational from state registers.
- Multiply iteration:
  - alu_op=ALU_ADD, alu_a=hi, alu_b = lo[0] ? mcand : 0.
  - carry = (alu_result < hi), unsigned compare.
  - {hi,lo} <= {carry, alu_result, lo[31:1]}.
- Divide iteration:
  - Shifted remainder s = {rem, quo[31]} is 33 bits; s32 = s[31:0].
  - alu_op=ALU_SUB, alu_a=s32, alu_b=dvs.
  - take = s[32] | (s32 >= dvs), unsigned.
  - rem <= take ? alu_result : s32.
  - quo <= {quo[30:0], take}.
  - The 32-bit wrap of alu_result is correct whenever s[32]=1.
- After count=31, go to DONE.
- State DONE, one cycle:
  - done=1.
  - result = lo (MUL), hi (MULHU), quo (DIVU), rem (REMU).
  - Next state IDLE.
- Latency: start sampled at edge N gives done=1 in the cycle following edge N+33. Throughput is one operation per 34 cycles; start may be asserted again in the cycle after DONE.
- Division by zero needs no special case. It naturally yields DIVU = 0xFFFFFFFF and REMU = op_a, as the ISA requires.
- start while busy: ignored, no queuing.
- kill in RUN or DONE: go to IDLE at the next edge. done is suppressed if not already asserted; result is not updated.
- kill together with start in IDLE: start is ignored.
- Operand inputs may change freely after accept.
- Reset mid-operation: immediate return to IDLE; no done.
- ALU ownership: alu_req=0 in IDLE and DONE, and alu_* values are then don't-care for the mux. The block never reads alu_result outside RUN.

Decomposition:
- MD_MUL, MD_MULHU, MD_DIVU and MD_REMU go in the shared parameters.vh beside the ALU_* opcodes. ALU_ADD and ALU_SUB are reused from there.
- Single module, no sub-module. The ALU stays a separate shared instance; the bench instantiates alu and wires it to alu_* directly.

Test Plan:
- MUL 7×6: start, md_op=0, a=7, b=6 → done exactly 34 cycles after the start cycle; result=42. alu_req high for exactly 32 cycles.
- MULHU and MUL with a=b=0xFFFFFFFF → MULHU=0xFFFFFFFE, MUL=0x00000001. This checks carry capture.
- DIVU/REMU 100/7 → 14 and 2. Large divisor 0xFFFFFFFF/0x80000001 → quotient 1, remainder 0x7FFFFFFE. This exercises the s[32] path.
- Divide by zero, a=0x00001234, b=0 → DIVU=0xFFFFFFFF, REMU=0x00001234.
- Protocol: start pulses during RUN are ignored; the result matches the first operation. kill at count=10 → IDLE next cycle, no done, result unchanged. A new start is then accepted.
- Asynchronous rst asserted mid-RUN, off a clock edge → all outputs 0 immediately. No done after release. The next operation, 9×9, returns 81.
